// File: rtl/video_timing.sv
// Parameterised raster timing generator: free-running pixel/line counters with
// a registered decode of sync, data-enable, coordinates and frame strobes.
module video_timing #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 62,
  parameter int unsigned H_BP     = 60,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 9,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 30,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic        I_clk_pixel,
  input  logic        I_reset_n,
  output logic        O_hsync,
  output logic        O_vsync,
  output logic        O_de,
  output logic [11:0] O_x,
  output logic [10:0] O_y,
  output logic        O_line_start,
  output logic        O_frame_start,
  output logic [7:0]  O_frame
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || V_TOTAL > 2048 ||
      H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_params
    $error("video_timing: illegal timing parameters");
  end

  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT_END    = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ON      = SYNC_POL[0];

  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [7:0]  frame_cnt;

  logic hsync_d, vsync_d, de_d, line_start_d, frame_start_d;

  // frame_cnt bumps on the counter wrap so that, after the output register
  // stage, O_frame changes in the same cycle O_frame_start is raised.
  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else begin
        v_cnt <= v_cnt + 11'd1;
      end
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_comb begin
    hsync_d       = ((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    vsync_d       = ((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END)) ? SYNC_ON : ~SYNC_ON;
    de_d          = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge I_clk_pixel) begin
    if (!I_reset_n) begin
      O_hsync       <= ~SYNC_ON;
      O_vsync       <= ~SYNC_ON;
      O_de          <= 1'b0;
      O_x           <= '0;
      O_y           <= '0;
      O_line_start  <= 1'b0;
      O_frame_start <= 1'b0;
      O_frame       <= '0;
    end else begin
      O_hsync       <= hsync_d;
      O_vsync       <= vsync_d;
      O_de          <= de_d;
      O_x           <= h_cnt;
      O_y           <= v_cnt;
      O_line_start  <= line_start_d;
      O_frame_start <= frame_start_d;
      O_frame       <= frame_cnt;
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Checks two small-raster instances (active-low and active-high sync) edge by
// edge against an arithmetic raster model, with random reset pulses.
module tb_video_timing;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_hs, a_vs, a_de, a_ls, a_fs;
  logic [11:0] a_x;
  logic [10:0] a_y;
  logic [7:0]  a_frame;
  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [11:0] b_x;
  logic [10:0] b_y;
  logic [7:0]  b_frame;

  video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(0)
  ) u_a (
    .I_clk_pixel(clk), .I_reset_n(rst_n),
    .O_hsync(a_hs), .O_vsync(a_vs), .O_de(a_de), .O_x(a_x), .O_y(a_y),
    .O_line_start(a_ls), .O_frame_start(a_fs), .O_frame(a_frame)
  );

  video_timing #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1)
  ) u_b (
    .I_clk_pixel(clk), .I_reset_n(rst_n),
    .O_hsync(b_hs), .O_vsync(b_vs), .O_de(b_de), .O_x(b_x), .O_y(b_y),
    .O_line_start(b_ls), .O_frame_start(b_fs), .O_frame(b_frame)
  );

  int vectors = 0;
  int miscompares = 0;
  int t = -1;            // cycles since reset release; -1 while in reset
  logic [7:0] prev_frame = '0;

  // Expected outputs after an edge whose preceding counter cycle is index t.
  function automatic void model(input int tt,
                                input int ha, input int hf, input int hs, input int hb,
                                input int va, input int vf, input int vs, input int vb,
                                input bit pol,
                                output logic [22:0] coord, output logic [12:0] flags);
    int ht, vt, h, v, fr;
    bit hsy, vsy, de, ls, fs;
    if (tt < 0) begin
      coord = '0;
      flags = {~pol, ~pol, 3'b000, 8'h00};
      return;
    end
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = tt % ht;
    v  = (tt / ht) % vt;
    fr = (tt / (ht * vt)) % 256;
    hsy = (h >= ha + hf) && (h < ha + hf + hs);
    vsy = (v >= va + vf) && (v < va + vf + vs);
    de  = (h < ha) && (v < va);
    ls  = (h == 0);
    fs  = (h == 0) && (v == 0);
    coord = {12'(h), 11'(v)};
    flags = {hsy ? pol : ~pol, vsy ? pol : ~pol, de, ls, fs, 8'(fr)};
  endfunction

  task automatic check_all();
    logic [22:0] ec;
    logic [12:0] ef;
    model(t, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, ec, ef);
    vectors++;
    assert ({a_x, a_y} === ec) else begin
      miscompares++;
      $error("FAIL a_coord t=%0d observed=%h expected=%h", t, {a_x, a_y}, ec);
    end
    vectors++;
    assert ({a_hs, a_vs, a_de, a_ls, a_fs, a_frame} === ef) else begin
      miscompares++;
      $error("FAIL a_flags t=%0d observed=%h expected=%h", t,
             {a_hs, a_vs, a_de, a_ls, a_fs, a_frame}, ef);
    end
    model(t, 10, 2, 3, 2, 5, 2, 2, 1, 1'b1, ec, ef);
    vectors++;
    assert ({b_x, b_y} === ec) else begin
      miscompares++;
      $error("FAIL b_coord t=%0d observed=%h expected=%h", t, {b_x, b_y}, ec);
    end
    vectors++;
    assert ({b_hs, b_vs, b_de, b_ls, b_fs, b_frame} === ef) else begin
      miscompares++;
      $error("FAIL b_flags t=%0d observed=%h expected=%h", t,
             {b_hs, b_vs, b_de, b_ls, b_fs, b_frame}, ef);
    end
    if (a_fs === 1'b1 && prev_frame == 8'd255) begin
      vectors++;
      assert (a_frame === 8'd0) else begin
        miscompares++;
        $error("FAIL frame_wrap observed=%0d expected=0", a_frame);
      end
    end
    prev_frame = a_frame;
  endtask

  // Drive reset level for the next edge, then check after that edge.
  task automatic step(input bit rn);
    rst_n = rn;
    @(posedge clk);
    if (rn) t++;
    else t = -1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int n;
    repeat (5) step(1'b0);
    repeat (3 * 48 + 5) step(1'b1);
    repeat (40) begin
      n = $urandom_range(10, 120);
      repeat (n) step(1'b1);
      n = $urandom_range(1, 3);
      repeat (n) step(1'b0);
    end
    // Uninterrupted run long enough for the 8-bit frame counter to wrap.
    repeat (257 * 48 + 10) step(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
